fp_add_arbiter: RTL and testbench

- Shares one combinational ieee754_float_adder among NUM_REQ requesters using round-robin arbitration.
- Registers the adder output into a single response stage with a valid/ready handshake, and tags each result with the winning requester's ID.
- Sits between multiple FP-producing clients and the single adder instance, so that no client needs its own adder.

---
 rtl/fp_add_arbiter_pkg.sv | 35 +++
 rtl/fp_add_arbiter_rr_arbiter.sv | 41 ++++
 rtl/ieee754_float_adder.sv | 90 +++++++++
 rtl/fp_add_arbiter.sv | 159 +++++++++++++++
 tb/tb_fp_add_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_arbiter_pkg.sv
// ==========================================================================
// fp_add_arbiter_pkg - shared constants, FSM state type and helpers. Rev 1.0
// ==========================================================================
`default_nettype none

package fp_add_arbiter_pkg;

  localparam int         FP_W       = 32;
  localparam logic [7:0] FP_EXP_MAX = 8'hFE;
  localparam int         STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    STALL = 2'd2
  } state_e;

  // Leading-zero count of a 27-bit mantissa+GRS field; 27 when all zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// ==========================================================================
// rr_arbiter - combinational round-robin picker starting at ptr. Rev 1.0
// ==========================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  localparam int POS_W = ID_W + 1;

  logic [POS_W-1:0] pos;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + POS_W'(i);
      if (pos >= POS_W'(NUM_REQ))
        pos = pos - POS_W'(NUM_REQ);
      if (en && !found && req[pos[ID_W-1:0]]) begin
        gnt[pos[ID_W-1:0]] = 1'b1;
        idx                = pos[ID_W-1:0];
        found              = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ieee754_float_adder.sv
// ==========================================================================
// ieee754_float_adder - combinational binary32 add, round-to-nearest-even,
// subnormals flushed to zero, overflow flagged on finite operands. Rev 1.0
// ==========================================================================
`default_nettype none

module ieee754_float_adder
  import fp_add_arbiter_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum,
  output logic            overflow
);

  logic            a_nan, b_nan, a_inf, b_inf, special;
  logic [FP_W-1:0] special_res;
  logic            swap;
  logic [FP_W-1:0] x, y;
  logic [7:0]      ediff;
  logic [23:0]     mx, my;
  logic [50:0]     y_shift;
  logic [26:0]     fx, fy, norm;
  logic [27:0]     raw;
  logic [4:0]      lz;
  logic [9:0]      exp_n, exp_r;
  logic            rnd_up;
  logic [24:0]     mant_r;
  logic [22:0]     frac;

  always_comb begin
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    special = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
      special_res = 32'h7FC0_0000;
    else if (a_inf)
      special_res = a;
    else
      special_res = b;
  end

  // x is always the operand of larger magnitude, so the result takes its sign.
  always_comb begin
    swap    = b[30:0] > a[30:0];
    x       = swap ? b : a;
    y       = swap ? a : b;
    mx      = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my      = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    ediff   = x[30:23] - y[30:23];
    y_shift = {my, 27'd0} >> ediff;
    fy      = (ediff > 8'd26) ? {26'd0, |my} : {y_shift[50:25], |y_shift[24:0]};
    fx      = {mx, 3'b000};
    raw     = (x[31] ^ y[31]) ? ({1'b0, fx} - {1'b0, fy}) : ({1'b0, fx} + {1'b0, fy});
    lz      = lzc27(raw[26:0]);
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_n = {2'b00, x[30:23]} + 10'd1;
    end else begin
      norm  = raw[26:0] << lz;
      exp_n = {2'b00, x[30:23]} - {5'd0, lz};
    end
    rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    exp_r  = mant_r[24] ? (exp_n + 10'd1) : exp_n;
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
  end

  // exp_r bit 9 set means the exponent went negative during normalisation.
  always_comb begin
    overflow = 1'b0;
    if (special) begin
      sum = special_res;
    end else if (raw == 28'd0) begin
      sum = {~(x[31] ^ y[31]) & x[31], 31'd0};
    end else if (!exp_r[9] && (exp_r[8:0] > {1'b0, FP_EXP_MAX})) begin
      sum      = {x[31], 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_r[9] || (exp_r == 10'd0)) begin
      sum = {x[31], 31'd0};
    end else begin
      sum = {x[31], exp_r[7:0], frac};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_arbiter.sv
// ==========================================================================
// fp_add_arbiter - round-robin sharing of one FP adder, registered tagged
// response. Optional counters via FP_ADD_ARBITER_STATS_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_data,
  output logic                    rsp_overflow,
  output logic                    busy
`ifdef FP_ADD_ARBITER_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]       stat_ovf
`endif
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [FP_W-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_ovf_q, rsp_ovf_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               stage_free, grant_en, accept;
  logic [FP_W-1:0]    add_a, add_b, add_sum;
  logic               add_ovf;

  // The stage can take a new result when empty or draining this same cycle.
  assign stage_free = (state_q == IDLE) || rsp_ready;
  assign grant_en   = stage_free && rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (grant_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);
  assign add_a     = req_a[FP_W*gnt_idx +: FP_W];
  assign add_b     = req_b[FP_W*gnt_idx +: FP_W];

  ieee754_float_adder u_adder (
    .a        (add_a),
    .b        (add_b),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    unique case (state_q)
      IDLE:         if (accept) state_d = VALID;
      VALID, STALL: begin
        if (accept)         state_d = VALID;
        else if (rsp_ready) state_d = IDLE;
        else                state_d = STALL;
      end
      default:      state_d = IDLE;
    endcase
    if (accept) begin
      rsp_id_d   = gnt_idx;
      rsp_data_d = add_sum;
      rsp_ovf_d  = add_ovf;
      rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign rsp_valid    = (state_q != IDLE);
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_overflow = rsp_ovf_q;
  assign busy         = rsp_valid;

`ifdef FP_ADD_ARBITER_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_grant
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (stat_clr)
        cnt_d = '0;
      else if (accept && gnt[gi] && (cnt_q != STAT_MAX))
        cnt_d = cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign stat_grants[gi*STAT_W +: STAT_W] = cnt_q;
  end

  logic [STAT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (stat_clr)
      ovf_cnt_d = '0;
    else if (accept && add_ovf && (ovf_cnt_q != STAT_MAX))
      ovf_cnt_d = ovf_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign stat_ovf = ovf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ==========================================================================
// tb_fp_add_arbiter - randomized scoreboard bench for fp_add_arbiter. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_data;
  logic            rsp_overflow, busy;
`ifdef FP_ADD_ARBITER_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_ovf;
  logic [15:0]     ovf_before;
`endif

  fp_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
`ifdef FP_ADD_ARBITER_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_grants  (stat_grants),
    .stat_ovf     (stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference adder: exact sum in double precision, then one RNE rounding to single.
  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:23] == 8'd0) return {f[31], 63'd0};
    return {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
  endfunction

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    real         s;
    logic [63:0] d;
    int          e;
    logic [30:0] mag;
    logic [28:0] rem;
    logic        up;
    s = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
    d = $realtobits(s);
    if (d[62:0] == 63'd0) return {1'b0, d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    mag = {e[7:0], d[51:29]};
    rem = d[28:0];
    up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && d[29]);
    mag = mag + 31'(up);
    if (mag[30:23] == 8'hFF) return {1'b1, d[63], 8'hFF, 23'd0};
    return {1'b0, d[63], mag};
  endfunction

  // Operands stay normal with exponent gap <= 28 so the double sum is exact.
  task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
    int ea, eb;
    if ($urandom_range(7, 0) == 0) ea = int'($urandom_range(254, 250));
    else                           ea = int'($urandom_range(254, 30));
    eb = ea + int'($urandom_range(56, 0)) - 28;
    if (eb < 30)  eb = 30;
    if (eb > 254) eb = 254;
    a = {1'($urandom), 8'(ea), 23'($urandom)};
    b = ($urandom_range(15, 0) == 0) ? 32'd0 : {1'($urandom), 8'(eb), 23'($urandom)};
  endtask

  typedef struct packed {
    logic [IW-1:0] id;
    logic          ovf;
    logic [31:0]   data;
  } exp_t;

  exp_t sb_q[$];

  // Model: grant = first valid requester scanning upward from ptr, mod N.
  int          m_ptr;
  bit          m_valid;
  int          m_g;
  logic [N-1:0] m_gnt;
  logic [32:0] m_r;
  bit          m_free;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr   = 0;
      m_valid = 1'b0;
      sb_q.delete();
      check("req_ready_in_reset", 64'(req_ready), 64'd0);
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      m_free = !m_valid || rsp_ready;
      m_g    = -1;
      m_gnt  = '0;
      if (m_free)
        for (int k = 0; k < N; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      if (m_g >= 0) m_gnt[m_g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(m_gnt));
      if (m_g >= 0) begin
        m_r = ref_add(req_a[32*m_g +: 32], req_b[32*m_g +: 32]);
        sb_q.push_back('{id: IW'(m_g), ovf: m_r[32], data: m_r[31:0]});
        m_ptr   = (m_g + 1) % N;
        m_valid = 1'b1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  exp_t mon_e;
  exp_t mon_held;
  bit   mon_stalled = 1'b0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (mon_stalled)
        check("stall_stable", 64'({rsp_id, rsp_overflow, rsp_data}), 64'(mon_held));
      if (rsp_ready) begin
        mon_stalled = 1'b0;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: got response id %0d data %h, expected none", rsp_id, rsp_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_id",   64'(rsp_id),       64'(mon_e.id));
          check("rsp_data", 64'(rsp_data),     64'(mon_e.data));
          check("rsp_ovf",  64'(rsp_overflow), 64'(mon_e.ovf));
        end
      end else begin
        mon_stalled = 1'b1;
        mon_held    = '{id: rsp_id, ovf: rsp_overflow, data: rsp_data};
      end
    end else begin
      mon_stalled = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  logic [31:0]   ta, tb_v;
  logic [IW-1:0] held_id;
  logic [31:0]   held_data;

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef FP_ADD_ARBITER_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (3) step();
    check("reset_rsp_valid", 64'(rsp_valid),    64'd0);
    check("reset_rsp_id",    64'(rsp_id),       64'd0);
    check("reset_rsp_data",  64'(rsp_data),     64'd0);
    check("reset_rsp_ovf",   64'(rsp_overflow), 64'd0);
    check("reset_busy",      64'(busy),         64'd0);
    check("reset_req_ready", 64'(req_ready),    64'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single requester 0: 1.0 + 1.0
    set_op(0, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    check("single_valid", 64'(rsp_valid),    64'd1);
    check("single_id",    64'(rsp_id),       64'd0);
    check("single_data",  64'(rsp_data),     64'h4000_0000);
    check("single_ovf",   64'(rsp_overflow), 64'd0);
    step();

    // All requesters continuously valid from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'h3F80_0000, (i == 2) ? 32'h4000_0000 : 32'h3F80_0000);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_order_id",   64'(rsp_id),   64'(c % N));
      check("rr_order_data", 64'(rsp_data), (c % N == 2) ? 64'h4040_0000 : 64'h4000_0000);
    end

    // Backpressure for 5 cycles, then release with same-cycle accept
    rsp_ready = 1'b0;
    held_id   = rsp_id;
    held_data = rsp_data;
    #1;
    check("bp_req_ready", 64'(req_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_valid",     64'(rsp_valid), 64'd1);
      check("bp_id",        64'(rsp_id),    64'(held_id));
      check("bp_data",      64'(rsp_data),  64'(held_data));
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'(4'b0001 << ((held_id + 1) % N)));
    step();
    check("bp_release_id", 64'(rsp_id), 64'((held_id + 1) % N));

    // Overflow from finite operands
`ifdef FP_ADD_ARBITER_STATS_EN
    ovf_before = stat_ovf;
`endif
    set_op(1, 32'h7F00_0000, 32'h7F00_0000);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    check("ovf_id",   64'(rsp_id),       64'd1);
    check("ovf_data", 64'(rsp_data),     64'h7F80_0000);
    check("ovf_flag", 64'(rsp_overflow), 64'd1);
`ifdef FP_ADD_ARBITER_STATS_EN
    check("stat_ovf_inc", 64'(stat_ovf), 64'(ovf_before + 16'd1));
`endif
    step();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        rand_pair(ta, tb_v);
        set_op(k, ta, tb_v);
      end
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(3, 0) != 0);
      step();
    end

    // Asynchronous reset while a response is stalled
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) step();
    rand_pair(ta, tb_v);
    set_op(0, ta, tb_v);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    check("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(rsp_valid), 64'd0);
    check("async_reset_busy",  64'(busy),      64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      rand_pair(ta, tb_v);
      set_op(k, ta, tb_v);
    end
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    check("post_reset_grant", 64'(req_ready), 64'b0010);
    step();
    check("post_reset_id", 64'(rsp_id), 64'd1);
    req_valid = '0;
    step();

`ifdef FP_ADD_ARBITER_STATS_EN
    set_op(0, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0001;
    repeat (65536) step();
    check("stat_saturate", 64'(stat_grants[15:0]), 64'hFFFF);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_clear_priority", 64'(stat_grants[15:0]), 64'd0);
    req_valid = '0;
    step();
`endif

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    check("drain_valid", 64'(rsp_valid), 64'd0);
    check("drain_queue", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
